uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
Controller that sequences uart_receiver: generates its 16x oversample clken from a programmable divisor, services its rdy/rdy_clr handshake, and buffers received bytes in a small FIFO. Downstream logic (CPU bus bridge, loader) reads bytes through a valid/ready stream. Sits between uart_receiver and the system interconnect, all in the clk_50m domain.

Parameters:
DEPTH, 8, FIFO depth in bytes; power of two, >= 2
DIV_W, 16, divisor register width
DEFAULT_DIV, 26, reset divisor (50 MHz / (115200*16) - 1)
TIMEOUT_TICKS, 512, oversample ticks of idle before rx_timeout (optional feature only)

Ports:
clk_50m  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
rx_en  in  1  receive enable; gates clken
cfg_we  in  1  load divisor
cfg_div  in  DIV_W  divisor value
clken  out  1  oversample tick to uart_receiver
rx_data  in  8  uart_receiver data
rx_rdy  in  1  uart_receiver rdy
rdy_clr  out  1  uart_receiver rdy_clr
m_data  out  8  head-of-FIFO byte
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts byte
level  out  $clog2(DEPTH+1)  bytes held
overflow  out  1  sticky: byte dropped
ovf_clr  in  1  clears overflow
rx_timeout  out  1  idle-with-data flag

Behaviour:
- Reset (rst=1, synchronous): divisor=DEFAULT_DIV, tick counter=0, FIFO empty, level=0, m_valid=0, m_data=0, overflow=0, rx_timeout=0, clken=0, FSM=IDLE. rdy_clr held 1 for every cycle rst=1, flushing any stale rdy in the receiver, which has no reset.
- Tick generator: DIV_W-bit counter; when rx_en=1, counts 0..div; clken=1 for exactly one cycle when counter==div, counter returns to 0 on that cycle. div=0 -> clken every cycle. rx_en=0 -> clken=0, counter held at 0.
- cfg_we=1: divisor<=cfg_div, counter<=0, no clken that cycle; new rate starts next cycle. cfg_we while a byte is in flight corrupts that byte; this is accepted and left to software.
- Handshake FSM:
  - IDLE: on rx_rdy=1 -> push rx_data into FIFO (subject to full rule), rdy_clr=1 this cycle, go to CLR.
  - CLR: rdy_clr=0; wait for rx_rdy=0, then go to IDLE. Each receiver byte is therefore pushed exactly once.
  - rdy_clr is 0 outside these cases.
- FIFO is first-word-fall-through:
  - A push at edge N gives m_valid=1 and m_data valid after edge N (1-cycle latency from rx_rdy sampled high).
  - Pop occurs when m_valid && m_ready.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- Full rule: push is accepted if level<DEPTH, or if level==DEPTH and a pop occurs the same cycle. Otherwise the byte is dropped, overflow<=1, and the FIFO is unchanged; the rdy_clr handshake still completes.
- Simultaneous push and pop: level unchanged. Push into empty with m_ready=1: no same-cycle bypass; the byte appears next cycle.
- overflow: ovf_clr clears it. If a set and a clear occur in the same cycle, set wins.
- m_ready with m_valid=0: ignored.

Optional Feature:
Macro UART_RX_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_TICKS+1)-bit idle counter increments on each clken while level>0 and saturates at TIMEOUT_TICKS.
  - The counter clears on push, pop, or level==0.
  - rx_timeout=1 while counter==TIMEOUT_TICKS.
- Undefined: no counter; rx_timeout tied 0. Port list is identical in both builds.

Decomposition:
- Package uart_pkg: FSM state enum (IDLE, CLR), DEFAULT_DIV and TIMEOUT_TICKS defaults, byte typedef.
- One sub-module, uart_rx_fifo: parameterised FWFT FIFO with push/pop/level/full/empty.
- Tick generator and FSM stay in uart_rx_ctrl.

Test Plan:
1. Reset, then cfg_div=3 with rx_en=1 -> clken pulses every 4 cycles. rx_en=0 -> clken=0. cfg_div=0 -> clken every cycle. rdy_clr=1 throughout reset.
2. Model rx_rdy high with rx_data=8'hA5 -> rdy_clr pulses 1 cycle; next cycle m_valid=1, m_data=A5, level=1. Hold rx_rdy 3 more cycles -> no second push.
3. Push 0x01..0x08 with m_ready=0 -> level=8. Push 0x09 -> dropped, overflow=1, FIFO still holds 01..08. Drain -> bytes 01..08 in order, then m_valid=0.
4. level=8, push 0x55 in the same cycle as a pop -> accepted, level stays 8, overflow unchanged. ovf_clr coincident with a drop -> overflow stays 1.
5. rst asserted with level=5 and FSM in CLR -> next cycle level=0, m_valid=0, overflow=0, divisor=26.
6. (UART_RX_TIMEOUT_EN) cfg_div=0, one byte pushed, no pop -> rx_timeout=1 after 512 clken. Pop -> rx_timeout=0 next cycle. Without macro -> rx_timeout always 0.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and defaults for the UART receive controller.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CLR  = 1'b1
    } rx_state_e;

    // 50 MHz / (115200 * 16) - 1
    localparam int c_default_div   = 26;
    localparam int c_timeout_ticks = 512;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : First-word-fall-through byte FIFO; head word visible while non-empty.
// Revision : 1.0
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = $clog2(DEPTH+1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;
    logic               w_push;
    logic               w_pop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == c_lvl_w'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    // A full FIFO still takes a word when the head leaves on the same edge.
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_lvl_w'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_lvl_w'(1);
            end
        end
    end

    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule : uart_rx_fifo
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Brief    : Oversample tick generator, rdy/rdy_clr handshake and receive FIFO
//            for uart_receiver. Optional idle timeout: UART_RX_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int DIV_W         = 16,
    parameter int DEFAULT_DIV   = c_default_div,
    parameter int TIMEOUT_TICKS = c_timeout_ticks
) (
    input  logic                         clk_50m,
    input  logic                         rst,
    input  logic                         rx_en,
    input  logic                         cfg_we,
    input  logic [DIV_W-1:0]             cfg_div,
    output logic                         clken,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_rdy,
    output logic                         rdy_clr,
    output logic [7:0]                   m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    input  logic                         ovf_clr,
    output logic                         rx_timeout
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             w_tick_hit;
    rx_state_e        r_state;
    rx_state_e        w_state_nxt;
    logic             w_push_req;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    logic             r_ovf;

    assign w_tick_hit = (r_cnt == r_div);

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_div <= DIV_W'(DEFAULT_DIV);
            r_cnt <= '0;
        end else if (cfg_we) begin
            r_div <= cfg_div;
            r_cnt <= '0;
        end else if (!rx_en || w_tick_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    assign clken = !rst && rx_en && !cfg_we && w_tick_hit;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // rdy_clr is held through reset because the receiver itself has no reset.
    always_comb begin
        w_state_nxt = r_state;
        w_push_req  = 1'b0;
        rdy_clr     = rst;
        case (r_state)
            IDLE: begin
                if (rx_rdy && !rst) begin
                    w_push_req  = 1'b1;
                    rdy_clr     = 1'b1;
                    w_state_nxt = CLR;
                end
            end
            CLR: begin
                if (!rx_rdy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign m_valid = !w_empty;
    assign w_pop   = m_valid && m_ready;
    assign w_push  = w_push_req && (!w_full || w_pop);
    assign w_drop  = w_push_req && w_full && !w_pop;

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk_50m),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (rx_data),
        .i_pop   (w_pop),
        .o_data  (m_data),
        .o_level (level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign overflow = r_ovf;

`ifdef UART_RX_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT_TICKS+1);

    logic [c_to_w-1:0] r_idle;

    always_ff @(posedge clk_50m) begin
        if (rst || w_push || w_pop || w_empty) begin
            r_idle <= '0;
        end else if (clken && (r_idle != c_to_w'(TIMEOUT_TICKS))) begin
            r_idle <= r_idle + c_to_w'(1);
        end
    end

    assign rx_timeout = (r_idle == c_to_w'(TIMEOUT_TICKS));
`else
    assign rx_timeout = 1'b0;
`endif

endmodule : uart_rx_ctrl
`default_nettype wire
